// File: rtl/fp_div_mant_iter.sv
// Iterative radix-2 restoring mantissa divider, one quotient bit per cycle.
// Produces the unnormalized quotient mantissa plus sticky and divide-by-zero.
module fp_div_mant_iter #(
    parameter int SP_STEPS = 49,
    parameter int HP_STEPS = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        MODE_FP,
    input  logic [7:0]  EXP_A,
    input  logic [7:0]  EXP_B,
    input  logic [22:0] MANT_A,
    input  logic [22:0] MANT_B,
    output logic        busy,
    output logic        done,
    output logic [48:0] mant,
    output logic        sticky,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic        mode_q;
    logic [23:0] d_q;
    logic [25:0] r_q;
    logic [48:0] q_q;
    logic [5:0]  cnt;

    logic        h_a;
    logic        h_b;
    logic [23:0] n_in;
    logic [23:0] d_in;
    logic        ge;
    logic [25:0] r_sub;
    logic [48:0] q_next;

    always_comb begin
        h_a  = |EXP_A;
        h_b  = |EXP_B;
        n_in = MODE_FP ? {h_a, MANT_A} : {13'b0, h_a, MANT_A[9:0]};
        d_in = MODE_FP ? {h_b, MANT_B} : {13'b0, h_b, MANT_B[9:0]};
    end

    // R < 2D always, so the restored remainder fits in 25 bits before shifting
    always_comb begin
        ge     = r_q >= {2'b00, d_q};
        r_sub  = ge ? (r_q - {2'b00, d_q}) : r_q;
        q_next = {q_q[47:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            d_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mant     <= '0;
            sticky   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        mode_q <= MODE_FP;
                        d_q    <= d_in;
                        if (d_in == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            mant     <= '0;
                            sticky   <= 1'b0;
                            div_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            r_q   <= {2'b00, n_in};
                            q_q   <= '0;
                            cnt   <= MODE_FP ? 6'(SP_STEPS) : 6'(HP_STEPS);
                        end
                    end
                end
                RUN: begin
                    r_q <= {r_sub[24:0], 1'b0};
                    q_q <= q_next;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mant     <= mode_q ? q_next
                                           : {28'b0, q_next[20:0]};
                        sticky   <= |r_sub;
                        div_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_mant_iter.sv
// Directed self-checking bench for fp_div_mant_iter.
// Expected quotients are floor(N * 2^(steps-1) / D), computed by hand.
`timescale 1ns/1ps
module tb_fp_div_mant_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        MODE_FP;
    logic [7:0]  EXP_A;
    logic [7:0]  EXP_B;
    logic [22:0] MANT_A;
    logic [22:0] MANT_B;
    logic        busy;
    logic        done;
    logic [48:0] mant;
    logic        sticky;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    fp_div_mant_iter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .MODE_FP  (MODE_FP),
        .EXP_A    (EXP_A),
        .EXP_B    (EXP_B),
        .MANT_A   (MANT_A),
        .MANT_B   (MANT_B),
        .busy     (busy),
        .done     (done),
        .mant     (mant),
        .sticky   (sticky),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [48:0] obs,
                         input logic [48:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic m, input logic [7:0] ea,
                           input logic [7:0] eb, input logic [22:0] ma,
                           input logic [22:0] mb);
        MODE_FP = m;
        EXP_A   = ea;
        EXP_B   = eb;
        MANT_A  = ma;
        MANT_B  = mb;
    endtask

    // Pulse start across one edge; returns with #1 after the accept edge
    task automatic issue();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the current sample point until done; also counts
    // busy samples, including the current one
    task automatic wait_done(input int budget, output int cyc,
                             output int busy_n);
        cyc    = 0;
        busy_n = busy ? 1 : 0;
        while (cyc <= budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (busy) busy_n++;
        end
    endtask

    int cyc;
    int bn;
    int seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_ops(1'b1, 8'd127, 8'd127, 23'h0, 23'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 49'(busy), 49'd0);
        check("rst_done", 49'(done), 49'd0);
        check("rst_mant", mant, 49'd0);
        check("rst_sticky", 49'(sticky), 49'd0);
        check("rst_dz", 49'(div_zero), 49'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single 1.0 / 1.0
        issue();
        check("sp11_busy_now", 49'(busy), 49'd1);
        wait_done(60, cyc, bn);
        check("sp11_lat", 49'(cyc), 49'd49);
        check("sp11_busy_cyc", 49'(bn), 49'd49);
        check("sp11_mant", mant, 49'h1_0000_0000_0000);
        check("sp11_sticky", 49'(sticky), 49'd0);
        check("sp11_dz", 49'(div_zero), 49'd0);
        check("sp11_busy_end", 49'(busy), 49'd0);
        @(posedge clk);
        #1;
        check("sp11_done_once", 49'(done), 49'd0);
        check("sp11_mant_hold", mant, 49'h1_0000_0000_0000);

        // single 1.0 / 1.5
        set_ops(1'b1, 8'd127, 8'd127, 23'h0, 23'h400000);
        issue();
        wait_done(60, cyc, bn);
        check("sp1_15_lat", 49'(cyc), 49'd49);
        check("sp1_15_mant", mant, 49'h0_AAAA_AAAA_AAAA);
        check("sp1_15_sticky", 49'(sticky), 49'd1);

        // single 1.5 / 1.0
        set_ops(1'b1, 8'd127, 8'd127, 23'h400000, 23'h0);
        issue();
        wait_done(60, cyc, bn);
        check("sp15_1_mant", mant, 49'h1_8000_0000_0000);
        check("sp15_1_sticky", 49'(sticky), 49'd0);

        // half 1.0 / 1.0 with garbage in the unused fraction bits
        set_ops(1'b0, 8'd15, 8'd15, 23'h7FFC00, 23'h0);
        issue();
        wait_done(60, cyc, bn);
        check("hp_lat", 49'(cyc), 49'd21);
        check("hp_mant", mant, 49'h10_0000);
        check("hp_sticky", 49'(sticky), 49'd0);

        // divide by zero, A = 2.0
        set_ops(1'b1, 8'd128, 8'd0, 23'h0, 23'h0);
        issue();
        check("dz_done", 49'(done), 49'd1);
        check("dz_flag", 49'(div_zero), 49'd1);
        check("dz_mant", mant, 49'd0);
        check("dz_busy", 49'(busy), 49'd0);
        @(posedge clk);
        #1;
        check("dz_done_once", 49'(done), 49'd0);

        // valid divisor afterwards: 2.0 / 1.0 mantissas are both 1.0
        set_ops(1'b1, 8'd128, 8'd127, 23'h0, 23'h0);
        issue();
        wait_done(60, cyc, bn);
        check("dz_clr_flag", 49'(div_zero), 49'd0);
        check("dz_clr_mant", mant, 49'h1_0000_0000_0000);

        // start re-issued mid-run is ignored
        set_ops(1'b1, 8'd127, 8'd127, 23'h0, 23'h400000);
        issue();
        repeat (9) @(posedge clk);
        #1;
        set_ops(1'b1, 8'd127, 8'd127, 23'h400000, 23'h0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(60, cyc, bn);
        check("reiss_lat", 49'(cyc + 10), 49'd49);
        check("reiss_mant", mant, 49'h0_AAAA_AAAA_AAAA);
        check("reiss_sticky", 49'(sticky), 49'd1);

        // back-to-back with start held high
        set_ops(1'b1, 8'd127, 8'd127, 23'h400000, 23'h0);
        start = 1'b1;
        @(posedge clk);
        #1;
        set_ops(1'b1, 8'd127, 8'd127, 23'h0, 23'h400000);
        wait_done(60, cyc, bn);
        check("b2b_lat1", 49'(cyc), 49'd49);
        check("b2b_mant1", mant, 49'h1_8000_0000_0000);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accept", 49'(busy), 49'd1);
        check("b2b_done_low", 49'(done), 49'd0);
        wait_done(60, cyc, bn);
        check("b2b_gap_low", 49'(cyc), 49'd49);
        check("b2b_mant2", mant, 49'h0_AAAA_AAAA_AAAA);

        // reset in the middle of a run
        set_ops(1'b1, 8'd127, 8'd127, 23'h400000, 23'h0);
        issue();
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy", 49'(busy), 49'd0);
        check("mrst_done", 49'(done), 49'd0);
        check("mrst_mant", mant, 49'd0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("mrst_no_done", 49'(seen), 49'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
